// File: rtl/bsg_mem_byte_store_coalescer.sv
// ---------------------------------------------------------------------------
// bsg_mem_byte_store_coalescer
//
// Purpose:
//   Write-side initiator for a byte-masked 1r1w sync memory. Sub-word stores
//   (1/2/4/.. bytes, right-aligned data) arrive over valid/ready. Consecutive
//   stores to the same word are merged into one held entry. The entry leaves
//   as a single registered masked write on eviction (store to another word),
//   on flush, on a snoop hit, or (optionally) after an idle timeout.
//
// Handshake:
//   A store is accepted on a cycle where v_i & ready_o. ready_o drops only in
//   a snoop-hit cycle. The memory side has no back-pressure: w_v_o is a
//   one-cycle pulse, and w_mask_o is 0 whenever w_v_o is 0.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   v_i, ready_o                store handshake
//   addr_i, size_i, data_i      byte address, log2(bytes), right-aligned data
//   flush_i                     evict the held entry (after merging any store)
//   snoop_v_i, snoop_addr_i     reader probe, word address
//   snoop_stall_o               reader must not sample memory this cycle
//   misaligned_o                pulse: the last accepted store was dropped
//   empty_o                     nothing held and no write in flight
//   w_v_o, w_mask_o, w_addr_o, w_data_o   registered masked write
//
// Optional feature:
//   BSG_STORE_COALESCE_TIMEOUT_EN -- when defined, an idle counter evicts the
//   held entry after timeout_p HOLD cycles with no accepted store.
// ---------------------------------------------------------------------------
module bsg_mem_byte_store_coalescer #(
    parameter  int width_p       = 32,
    parameter  int els_p         = 64,
    parameter  int timeout_p     = 16,
    localparam int mask_width_lp = width_p >> 3,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int off_width_lp  = (mask_width_lp > 1) ? $clog2(mask_width_lp) : 1,
    localparam int size_width_lp = ((off_width_lp + 1) > 1) ? $clog2(off_width_lp + 1) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  v_i,
    output logic                                  ready_o,
    input  logic [addr_width_lp+off_width_lp-1:0] addr_i,
    input  logic [size_width_lp-1:0]              size_i,
    input  logic [width_p-1:0]                    data_i,
    input  logic                                  flush_i,
    input  logic                                  snoop_v_i,
    input  logic [addr_width_lp-1:0]              snoop_addr_i,
    output logic                                  snoop_stall_o,
    output logic                                  misaligned_o,
    output logic                                  empty_o,
    output logic                                  w_v_o,
    output logic [mask_width_lp-1:0]              w_mask_o,
    output logic [addr_width_lp-1:0]              w_addr_o,
    output logic [width_p-1:0]                    w_data_o
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;

    state_e                     state_q, state_d;
    logic [addr_width_lp-1:0]   hold_addr_q, hold_addr_d;
    logic [mask_width_lp-1:0]   hold_mask_q, hold_mask_d;
    logic [width_p-1:0]         hold_data_q, hold_data_d;
    logic                       flush_pend_q, flush_pend_d;
    logic                       snoop_stall_q;
    logic                       misaligned_q;
    logic                       w_v_q;
    logic [mask_width_lp-1:0]   w_mask_q;
    logic [addr_width_lp-1:0]   w_addr_q;
    logic [width_p-1:0]         w_data_q;

    // ---------------- store decode ----------------
    logic [off_width_lp-1:0]    st_off;
    logic [addr_width_lp-1:0]   st_word;
    logic [31:0]                st_nbytes;
    logic                       st_aligned;
    logic [mask_width_lp-1:0]   st_mask;
    logic [width_p-1:0]         st_data;
    logic [width_p-1:0]         merge_data;

    assign st_off    = addr_i[off_width_lp-1:0];
    assign st_word   = addr_i[addr_width_lp+off_width_lp-1:off_width_lp];
    assign st_nbytes = 32'd1 << size_i;
    assign st_data   = data_i << {st_off, 3'b000};

    // Offset must be a multiple of the size, and the access must fit in a word.
    assign st_aligned = (st_nbytes != 32'd0)
                     && (st_nbytes <= 32'(mask_width_lp))
                     && (32'(st_off) < 32'(mask_width_lp))
                     && ((32'(st_off) & (st_nbytes - 32'd1)) == 32'd0);

    always_comb begin
        st_mask = '0;
        for (int i = 0; i < mask_width_lp; i++) begin
            st_mask[i] = (32'(i) >= 32'(st_off)) && (32'(i) < 32'(st_off) + st_nbytes);
        end
    end

    // New bytes overwrite old ones lane by lane.
    always_comb begin
        merge_data = hold_data_q;
        for (int i = 0; i < mask_width_lp; i++) begin
            if (st_mask[i]) merge_data[8*i +: 8] = st_data[8*i +: 8];
        end
    end

    // ---------------- handshake ----------------
    logic snoop_hit;
    logic accept;
    logic store_ok;
    logic flush_eff;
    logic timeout_hit;

    assign snoop_hit = snoop_v_i && (state_q == HOLD) && (snoop_addr_i == hold_addr_q);
    assign ready_o   = ~snoop_hit;
    assign accept    = v_i && ready_o;
    assign store_ok  = accept && st_aligned;
    assign flush_eff = flush_i || flush_pend_q;

`ifdef BSG_STORE_COALESCE_TIMEOUT_EN
    localparam int cnt_width_lp = ((timeout_p + 1) > 1) ? $clog2(timeout_p + 1) : 1;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;

    // Fires on the last idle cycle so the write lands timeout_p cycles after
    // the entry stopped receiving stores.
    assign timeout_hit = (state_q == HOLD) && !accept
                      && (cnt_q == cnt_width_lp'(timeout_p - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------- next state ----------------
    logic                     emit;
    logic [addr_width_lp-1:0] emit_addr;
    logic [mask_width_lp-1:0] emit_mask;
    logic [width_p-1:0]       emit_data;

    always_comb begin
        state_d      = state_q;
        hold_addr_d  = hold_addr_q;
        hold_mask_d  = hold_mask_q;
        hold_data_d  = hold_data_q;
        flush_pend_d = 1'b0;
        emit         = 1'b0;
        emit_addr    = hold_addr_q;
        emit_mask    = hold_mask_q;
        emit_data    = hold_data_q;

        if (snoop_hit) begin
            // No store can be accepted this cycle; the held entry goes out.
            emit    = 1'b1;
            state_d = EMPTY;
        end else if (store_ok) begin
            if ((state_q == HOLD) && (st_word == hold_addr_q)) begin
                hold_mask_d = hold_mask_q | st_mask;
                hold_data_d = merge_data;
            end else begin
                emit        = (state_q == HOLD);
                hold_addr_d = st_word;
                hold_mask_d = st_mask;
                hold_data_d = st_data;
            end
            state_d = HOLD;
            if (flush_eff) begin
                if (emit) begin
                    // Output register is taken by the evicted entry; the new
                    // one is flushed on the following cycle.
                    flush_pend_d = 1'b1;
                end else begin
                    emit      = 1'b1;
                    emit_addr = hold_addr_d;
                    emit_mask = hold_mask_d;
                    emit_data = hold_data_d;
                    state_d   = EMPTY;
                end
            end
        end else if ((state_q == HOLD) && (flush_eff || timeout_hit)) begin
            emit    = 1'b1;
            state_d = EMPTY;
        end
    end

`ifdef BSG_STORE_COALESCE_TIMEOUT_EN
    always_comb begin
        cnt_d = '0;
        if ((state_q == HOLD) && (state_d == HOLD) && !accept) begin
            cnt_d = cnt_q + cnt_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
`endif

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= EMPTY;
            hold_addr_q   <= '0;
            hold_mask_q   <= '0;
            hold_data_q   <= '0;
            flush_pend_q  <= 1'b0;
            snoop_stall_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_addr_q   <= hold_addr_d;
            hold_mask_q   <= hold_mask_d;
            hold_data_q   <= hold_data_d;
            flush_pend_q  <= flush_pend_d;
            snoop_stall_q <= snoop_hit;
            misaligned_q  <= accept && !st_aligned;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_q    <= 1'b0;
            w_mask_q <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            w_v_q    <= emit;
            w_mask_q <= emit ? emit_mask : '0;
            if (emit) begin
                w_addr_q <= emit_addr;
                w_data_q <= emit_data;
            end
        end
    end

    // ---------------- outputs ----------------
    // Stall covers the hit cycle and the cycle the write is in flight.
    assign snoop_stall_o = snoop_hit || snoop_stall_q;
    assign misaligned_o  = misaligned_q;
    assign empty_o       = (state_q == EMPTY) && !w_v_q;
    assign w_v_o         = w_v_q;
    assign w_mask_o      = w_mask_q;
    assign w_addr_o      = w_addr_q;
    assign w_data_o      = w_data_q;

endmodule

// File: tb/tb_bsg_mem_byte_store_coalescer.sv
// ---------------------------------------------------------------------------
// tb_bsg_mem_byte_store_coalescer
//
// Directed vectors with hand-computed writes. The driver pushes every write
// it expects into exp_q; a monitor on the falling edge pops and compares each
// write the DUT presents. Cycle-specific behaviour (ready, stall, pulse
// timing, reset) is checked inline by the driver.
// ---------------------------------------------------------------------------
module tb_bsg_mem_byte_store_coalescer;

    localparam int W  = 32;
    localparam int M  = 4;
    localparam int AW = 6;
    localparam int BW = 8;
    localparam int SW = 2;
    localparam int EW = AW + M + W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          v_i = 1'b0;
    logic          ready_o;
    logic [BW-1:0] addr_i = '0;
    logic [SW-1:0] size_i = '0;
    logic [W-1:0]  data_i = '0;
    logic          flush_i = 1'b0;
    logic          snoop_v_i = 1'b0;
    logic [AW-1:0] snoop_addr_i = '0;
    logic          snoop_stall_o;
    logic          misaligned_o;
    logic          empty_o;
    logic          w_v_o;
    logic [M-1:0]  w_mask_o;
    logic [AW-1:0] w_addr_o;
    logic [W-1:0]  w_data_o;

    bsg_mem_byte_store_coalescer #(
        .width_p   (W),
        .els_p     (64),
        .timeout_p (4)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .v_i           (v_i),
        .ready_o       (ready_o),
        .addr_i        (addr_i),
        .size_i        (size_i),
        .data_i        (data_i),
        .flush_i       (flush_i),
        .snoop_v_i     (snoop_v_i),
        .snoop_addr_i  (snoop_addr_i),
        .snoop_stall_o (snoop_stall_o),
        .misaligned_o  (misaligned_o),
        .empty_o       (empty_o),
        .w_v_o         (w_v_o),
        .w_mask_o      (w_mask_o),
        .w_addr_o      (w_addr_o),
        .w_data_o      (w_data_o)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int vec_cnt  = 0;
    int fail_cnt = 0;
    int mis_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [AW-1:0] a, input logic [M-1:0] m,
                                          input logic [W-1:0] d);
        return {a, m, d};
    endfunction

    function automatic logic [W-1:0] bytemask(input logic [M-1:0] m);
        logic [W-1:0] r;
        for (int i = 0; i < M; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    // Monitor: compares every presented write against the expected queue.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (w_v_o) begin
                    if (exp_q.size() == 0) begin
                        vec_cnt++;
                        fail_cnt++;
                        $display("FAIL unexpected_write: got addr 0x%0h mask 0x%0h data 0x%0h, expected none",
                                 w_addr_o, w_mask_o, w_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", 64'(w_addr_o), 64'(e[EW-1 -: AW]));
                        chk("write_mask", 64'(w_mask_o), 64'(e[W +: M]));
                        chk("write_data", 64'(w_data_o & bytemask(e[W +: M])),
                            64'(e[W-1:0] & bytemask(e[W +: M])));
                    end
                end else begin
                    chk("idle_mask_zero", 64'(w_mask_o), 64'd0);
                end
                if (misaligned_o) mis_seen++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [BW-1:0] a, input logic [SW-1:0] s, input logic [W-1:0] d);
        v_i    = 1'b1;
        addr_i = a;
        size_i = s;
        data_i = d;
    endtask

    task automatic store(input logic [BW-1:0] a, input logic [SW-1:0] s, input logic [W-1:0] d);
        set_store(a, s, d);
        cyc();
        v_i = 1'b0;
    endtask

    task automatic flush();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #3;
        chk("reset_w_v", 64'(w_v_o), 64'd0);
        chk("reset_w_mask", 64'(w_mask_o), 64'd0);
        chk("reset_w_addr", 64'(w_addr_o), 64'd0);
        chk("reset_w_data", 64'(w_data_o), 64'd0);
        chk("reset_empty", 64'(empty_o), 64'd1);
        chk("reset_stall", 64'(snoop_stall_o), 64'd0);
        chk("reset_misaligned", 64'(misaligned_o), 64'd0);
        #19 rst_n = 1'b1;
        cyc();

        // 1. four byte stores coalesce into one full-word write
        store(8'h40, 2'd0, 32'h11);
        store(8'h41, 2'd0, 32'h22);
        store(8'h42, 2'd0, 32'h33);
        store(8'h43, 2'd0, 32'h44);
        chk("t1_no_write_while_merging", 64'(w_v_o), 64'd0);
        chk("t1_not_empty", 64'(empty_o), 64'd0);
        exp_q.push_back(ent(6'h10, 4'hF, 32'h44332211));
        flush();
        chk("t1_flush_write", 64'(w_v_o), 64'd1);
        chk("t1_empty_in_flight", 64'(empty_o), 64'd0);
        cyc();
        chk("t1_empty_after", 64'(empty_o), 64'd1);

        // flush with nothing held does nothing
        flush();
        chk("flush_empty_no_write", 64'(w_v_o), 64'd0);

        // 2. different-word store evicts, new store held
        store(8'h06, 2'd1, 32'hBEEF);
        exp_q.push_back(ent(6'h01, 4'hC, 32'hBEEF0000));
        store(8'h08, 2'd0, 32'h5A);
        chk("t2_evict_v", 64'(w_v_o), 64'd1);
        chk("t2_evict_addr", 64'(w_addr_o), 64'd1);
        chk("t2_evict_mask", 64'(w_mask_o), 64'hC);
        chk("t2_evict_hi_half", 64'(w_data_o[31:16]), 64'hBEEF);
        exp_q.push_back(ent(6'h02, 4'h1, 32'h0000005A));
        flush();
        cyc();

        // 3. misaligned word store dropped
        store(8'h02, 2'd2, 32'hDEADBEEF);
        chk("t3_mis_pulse", 64'(misaligned_o), 64'd1);
        chk("t3_empty", 64'(empty_o), 64'd1);
        chk("t3_no_write", 64'(w_v_o), 64'd0);
        cyc();
        chk("t3_mis_one_cycle", 64'(misaligned_o), 64'd0);

        // overwrite + partial merge: lane1 never written
        store(8'h30, 2'd0, 32'hAA);
        store(8'h30, 2'd0, 32'hBB);
        store(8'h32, 2'd1, 32'hCCDD);
        exp_q.push_back(ent(6'h0C, 4'hD, 32'hCCDD00BB));
        flush();
        cyc();

        // store and flush in the same cycle: merged entry goes out
        set_store(8'h3C, 2'd0, 32'h12);
        exp_q.push_back(ent(6'h0F, 4'h1, 32'h12));
        flush();
        v_i = 1'b0;
        chk("store_flush_same_cycle", 64'(w_v_o), 64'd1);
        cyc();

        // 4. snoop miss then snoop hit with a pending store
        store(8'h14, 2'd0, 32'h77);
        snoop_v_i    = 1'b1;
        snoop_addr_i = 6'd6;
        #1;
        chk("t4_miss_stall", 64'(snoop_stall_o), 64'd0);
        chk("t4_miss_ready", 64'(ready_o), 64'd1);
        snoop_addr_i = 6'd5;
        set_store(8'h20, 2'd0, 32'h99);
        #1;
        chk("t4_hit_ready", 64'(ready_o), 64'd0);
        chk("t4_hit_stall", 64'(snoop_stall_o), 64'd1);
        exp_q.push_back(ent(6'h05, 4'h1, 32'h77));
        cyc();
        snoop_v_i = 1'b0;
        #1;
        chk("t4_write_out", 64'(w_v_o), 64'd1);
        chk("t4_stall_2nd_cycle", 64'(snoop_stall_o), 64'd1);
        chk("t4_ready_back", 64'(ready_o), 64'd1);
        cyc();
        v_i = 1'b0;
        chk("t4_stall_drop", 64'(snoop_stall_o), 64'd0);
        chk("t4_store_held", 64'(empty_o), 64'd0);
        exp_q.push_back(ent(6'h08, 4'h1, 32'h99));
        flush();
        cyc();

        // 5. reset mid-HOLD discards the entry
        store(8'h10, 2'd0, 32'h66);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_w_v", 64'(w_v_o), 64'd0);
        chk("t5_w_mask", 64'(w_mask_o), 64'd0);
        chk("t5_empty", 64'(empty_o), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        flush();
        chk("t5_no_write_after", 64'(w_v_o), 64'd0);
        cyc();

        // 6. idle held entry: timeout eviction only when the feature is built
        store(8'h2C, 2'd0, 32'h5C);
`ifdef BSG_STORE_COALESCE_TIMEOUT_EN
        exp_q.push_back(ent(6'h0B, 4'h1, 32'h5C));
        repeat (4) cyc();
        chk("t6_timeout_write", 64'(w_v_o), 64'd1);
        cyc();
        chk("t6_empty_after_timeout", 64'(empty_o), 64'd1);
`else
        repeat (4) cyc();
        chk("t6_no_timeout_write", 64'(w_v_o), 64'd0);
        repeat (8) cyc();
        chk("t6_still_held", 64'(empty_o), 64'd0);
        exp_q.push_back(ent(6'h0B, 4'h1, 32'h5C));
        flush();
        chk("t6_flush_write", 64'(w_v_o), 64'd1);
`endif

        repeat (3) cyc();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("misaligned_count", 64'(mis_seen), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
